id_exe_stage_reg: RTL

//  Decode->execute pipeline boundary register for the ARM core. Captures one decoded

---
 rtl/id_exe_stage_reg_pkg.sv | 37 +++
 rtl/id_exe_stage_reg_if.sv | 49 ++++
 rtl/pipe_skid_buf.sv | 56 +++++
 rtl/id_exe_stage_reg.sv | 57 +++++
 4 files changed

// File: rtl/id_exe_stage_reg_pkg.sv
// rtl/id_exe_stage_reg_pkg.sv - shared widths, ALU command codes and payload sizing for the ID/EXE boundary.
// ID_EXE_FWD_EN adds the src1/src2 forwarding indices to the payload width.
package id_exe_stage_reg_pkg;

  localparam int REGISTER_LEN = 32;
  localparam int REG_IDX_W    = 4;
  localparam int EXE_CMD_W    = 4;
  localparam int STATUS_W     = 4;
  localparam int SHIFT_OP_W   = 12;
  localparam int SIMM24_W     = 24;

  // exe_cmd, five control flags, status, shift_operand, imm, simm24
  localparam int CTRL_W = EXE_CMD_W + 5 + STATUS_W + SHIFT_OP_W + 1 + SIMM24_W;

  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_MOV = 4'b0001,
    EXE_MVN = 4'b1001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000
  } exe_cmd_e;

  function automatic int payload_w(input int dw, input int ri);
`ifdef ID_EXE_FWD_EN
    return 3 * dw + CTRL_W + 3 * ri;
`else
    return 3 * dw + CTRL_W + ri;
`endif
  endfunction

  localparam int ID_EXE_PAYLOAD_W = payload_w(REGISTER_LEN, REG_IDX_W);

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// rtl/id_exe_stage_reg_if.sv - one decoded-instruction beat with valid/ready handshake.
// ID_EXE_FWD_EN adds src1/src2 register indices for the forwarding unit.
interface id_exe_stage_reg_if
  import id_exe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_IDX = 4
);

  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     pc;
  logic [EXE_CMD_W-1:0]  exe_cmd;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  wb_en;
  logic                  b;
  logic                  s;
  logic [STATUS_W-1:0]   status;
  logic [DATA_W-1:0]     val_rn;
  logic [DATA_W-1:0]     val_rm;
  logic [SHIFT_OP_W-1:0] shift_operand;
  logic                  imm;
  logic [SIMM24_W-1:0]   simm24;
  logic [REG_IDX-1:0]    dest;
`ifdef ID_EXE_FWD_EN
  logic [REG_IDX-1:0]    src1;
  logic [REG_IDX-1:0]    src2;
`endif

  modport master (
    output valid, pc, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, status,
           val_rn, val_rm, shift_operand, imm, simm24, dest,
`ifdef ID_EXE_FWD_EN
           src1, src2,
`endif
    input  ready
  );

  modport slave (
    input  valid, pc, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, status,
           val_rn, val_rm, shift_operand, imm, simm24, dest,
`ifdef ID_EXE_FWD_EN
           src1, src2,
`endif
    output ready
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry valid/ready skid buffer with registered ready and flush.
// Full throughput with no combinational path from out_tready to in_tready.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_tvalid,
  output logic         in_tready,
  input  logic [W-1:0] in_tdata,
  output logic         out_tvalid,
  input  logic         out_tready,
  output logic [W-1:0] out_tdata
);

  logic         main_v;
  logic         skid_v;
  logic [W-1:0] main_d;
  logic [W-1:0] skid_d;
  logic         accept;
  logic         emit;

  assign in_tready  = !skid_v;
  assign out_tvalid = main_v;
  assign out_tdata  = main_d;
  assign accept     = in_tvalid & in_tready;
  assign emit       = main_v & out_tready;

  // accept is always 0 while skid_v, so the skid branch only drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (emit) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (!main_v || emit) begin
      main_v <= accept;
      if (accept) begin
        main_d <= in_tdata;
      end
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_d <= in_tdata;
    end
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// rtl/id_exe_stage_reg.sv - decode->execute pipeline register: packs the beat into a skid buffer.
// ID_EXE_FWD_EN carries src1/src2 alongside the payload.
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = REGISTER_LEN,
  parameter int REG_IDX = REG_IDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  id_exe_stage_reg_if.slave   in_bus,
  id_exe_stage_reg_if.master  out_bus,
  output logic                out_is_mem_cmd
);

  localparam int PW = payload_w(DATA_W, REG_IDX);

  logic [PW-1:0] in_data;
  logic [PW-1:0] out_data;

`ifdef ID_EXE_FWD_EN
  assign in_data = {in_bus.pc, in_bus.exe_cmd, in_bus.mem_r_en, in_bus.mem_w_en,
                    in_bus.wb_en, in_bus.b, in_bus.s, in_bus.status,
                    in_bus.val_rn, in_bus.val_rm, in_bus.shift_operand, in_bus.imm,
                    in_bus.simm24, in_bus.dest, in_bus.src1, in_bus.src2};
  assign {out_bus.pc, out_bus.exe_cmd, out_bus.mem_r_en, out_bus.mem_w_en,
          out_bus.wb_en, out_bus.b, out_bus.s, out_bus.status,
          out_bus.val_rn, out_bus.val_rm, out_bus.shift_operand, out_bus.imm,
          out_bus.simm24, out_bus.dest, out_bus.src1, out_bus.src2} = out_data;
`else
  assign in_data = {in_bus.pc, in_bus.exe_cmd, in_bus.mem_r_en, in_bus.mem_w_en,
                    in_bus.wb_en, in_bus.b, in_bus.s, in_bus.status,
                    in_bus.val_rn, in_bus.val_rm, in_bus.shift_operand, in_bus.imm,
                    in_bus.simm24, in_bus.dest};
  assign {out_bus.pc, out_bus.exe_cmd, out_bus.mem_r_en, out_bus.mem_w_en,
          out_bus.wb_en, out_bus.b, out_bus.s, out_bus.status,
          out_bus.val_rn, out_bus.val_rm, out_bus.shift_operand, out_bus.imm,
          out_bus.simm24, out_bus.dest} = out_data;
`endif

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_tvalid  (in_bus.valid),
    .in_tready  (in_bus.ready),
    .in_tdata   (in_data),
    .out_tvalid (out_bus.valid),
    .out_tready (out_bus.ready),
    .out_tdata  (out_data)
  );

  // Val2 generator needs this to select the 12-bit memory offset form
  assign out_is_mem_cmd = out_bus.mem_r_en | out_bus.mem_w_en;

endmodule
